picorv32_pcpi_muldiv: RTL and testbench

PICORV32_PCPI_MULDIV -- requirements
Module: picorv32_pcpi_muldiv

---
 rtl/picorv32_pcpi_pkg.sv | 48 ++++
 rtl/picorv32_pcpi_div_core.sv | 63 ++++++
 rtl/picorv32_pcpi_muldiv.sv | 202 ++++++++++++++++++++
 tb/tb_picorv32_pcpi_muldiv.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_pcpi_pkg.sv
// Shared decode constants, operation and FSM state types for the PCPI
// multiply/divide coprocessor.
package picorv32_pcpi_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL  = 3'd2,
    DIV  = 3'd3,
    DONE = 3'd4
  } state_e;

  // funct3 bit 2 selects divide, bit 1 selects remainder, bit 0 selects unsigned
  function automatic logic op_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  function automatic logic op_div_signed(input logic [2:0] f3);
    return f3[2] & ~f3[0];
  endfunction

  function automatic logic op_rs1_signed(input logic [2:0] f3);
    return (f3 == OP_MULH) || (f3 == OP_MULHSU);
  endfunction

  function automatic logic op_rs2_signed(input logic [2:0] f3);
    return f3 == OP_MULH;
  endfunction

endpackage

// File: rtl/picorv32_pcpi_div_core.sv
// Restoring unsigned divider: one quotient bit per step, with its own
// step counter. Operates on operand magnitudes supplied by the parent.
module picorv32_pcpi_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt,
  output logic            last
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   acc;
  logic [XLEN:0]   diff;

  // Partial remainder stays below the divisor, so the shifted value fits
  // in XLEN+1 bits and the top bit of the difference is the borrow.
  always_comb begin
    acc  = {rem, quo[XLEN-1]};
    diff = acc - {1'b0, dvs};
    if (!diff[XLEN]) begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = acc[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end
  end

  assign last = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (load) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
    end else if (step) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(XLEN);
    end else if (step && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/picorv32_pcpi_muldiv.sv
// PCPI coprocessor for RV32M/RV64M-style multiply and divide: carry-save
// shift-add multiplier plus optional restoring divider, one request at a time.
module picorv32_pcpi_muldiv
  import picorv32_pcpi_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int STEPS_AT_ONCE = 1,
  parameter int ENABLE_DIV    = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready,
  output logic            busy
);

  localparam int              W2     = 2 * XLEN;
  localparam int              CW     = $clog2(W2) + 1;
  localparam logic [CW-1:0]   K_MUL  = CW'(XLEN / STEPS_AT_ONCE);
  localparam logic [CW-1:0]   K_MULH = CW'(W2 / STEPS_AT_ONCE);
  localparam logic [XLEN-1:0] XMIN   = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state;
  state_e          state_nxt;
  muldiv_op_e      op;
  muldiv_op_e      insn_op;
  logic [CW-1:0]   cnt;
  logic            insn_match;
  logic            insn_unused;

  logic [W2-1:0]   mul_a;
  logic [W2-1:0]   mul_b;
  logic [W2-1:0]   acc_sum;
  logic [W2-1:0]   acc_carry;
  logic [W2-1:0]   ms_a;
  logic [W2-1:0]   ms_b;
  logic [W2-1:0]   ms_s;
  logic [W2-1:0]   ms_c;
  logic [W2-1:0]   ms_add;
  logic [W2-1:0]   ms_tmp;
  logic [W2-1:0]   mul_total;

  logic            op_div;
  logic            div_zero;
  logic            div_ovf;
  logic            div_skip;
  logic            neg_q;
  logic            neg_r;
  logic            div_load;
  logic            div_step;
  logic            div_last;
  logic [XLEN-1:0] div_dividend;
  logic [XLEN-1:0] div_divisor;
  logic [XLEN-1:0] div_quo_nxt;
  logic [XLEN-1:0] div_rem_nxt;
  logic [XLEN-1:0] div_result;

  assign insn_op     = muldiv_op_e'(pcpi_insn[14:12]);
  assign insn_match  = (pcpi_insn[6:0] == OPCODE_OP) && (pcpi_insn[31:25] == FUNCT7_MULDIV) &&
                       ((ENABLE_DIV != 0) || !pcpi_insn[14]);
  assign insn_unused = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // Divide corner cases are resolved in LOAD from the live operands.
  assign op_div   = op_is_div(op);
  assign div_zero = op_div && (pcpi_rs2 == '0);
  assign div_ovf  = op_div_signed(op) && (pcpi_rs1 == XMIN) && (pcpi_rs2 == '1);
  assign div_skip = div_zero || div_ovf;

  assign div_dividend = (op_div_signed(op) && pcpi_rs1[XLEN-1]) ? -pcpi_rs1 : pcpi_rs1;
  assign div_divisor  = (op_div_signed(op) && pcpi_rs2[XLEN-1]) ? -pcpi_rs2 : pcpi_rs2;
  assign div_load     = (state == LOAD);
  assign div_step     = (state == DIV);
  assign div_result   = op_is_rem(op) ? (neg_r ? -div_rem_nxt : div_rem_nxt)
                                      : (neg_q ? -div_quo_nxt : div_quo_nxt);

  always_comb begin
    state_nxt  = state;
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: if (pcpi_valid && insn_match) state_nxt = LOAD;
      LOAD: begin
        pcpi_wait = 1'b1;
        busy      = 1'b1;
        if (!pcpi_valid)   state_nxt = IDLE;
        else if (op_div)   state_nxt = div_skip ? DONE : DIV;
        else               state_nxt = MUL;
      end
      MUL: begin
        pcpi_wait = 1'b1;
        busy      = 1'b1;
        if (!pcpi_valid)            state_nxt = IDLE;
        else if (cnt == CW'(1))     state_nxt = DONE;
      end
      DIV: begin
        pcpi_wait = 1'b1;
        busy      = 1'b1;
        if (!pcpi_valid)   state_nxt = IDLE;
        else if (div_last) state_nxt = DONE;
      end
      DONE: begin
        pcpi_wait  = 1'b1;
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        busy       = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Carry-save steps keep the per-bit path free of carry propagation; the
  // single full add below only feeds the result register on the last step.
  always_comb begin
    ms_a   = mul_a;
    ms_b   = mul_b;
    ms_s   = acc_sum;
    ms_c   = acc_carry;
    ms_add = '0;
    ms_tmp = '0;
    for (int i = 0; i < STEPS_AT_ONCE; i++) begin
      ms_add = ms_a[0] ? ms_b : '0;
      ms_tmp = ms_s ^ ms_c ^ ms_add;
      ms_c   = ((ms_s & ms_c) | (ms_s & ms_add) | (ms_c & ms_add)) << 1;
      ms_s   = ms_tmp;
      ms_a   = ms_a >> 1;
      ms_b   = ms_b << 1;
    end
    mul_total = ms_s + ms_c;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      op      <= OP_MUL;
      cnt     <= '0;
      pcpi_rd <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (pcpi_valid && insn_match) op <= insn_op;
        LOAD: begin
          cnt <= (op == OP_MUL) ? K_MUL : K_MULH;
          if (div_zero)     pcpi_rd <= op_is_rem(op) ? pcpi_rs1 : '1;
          else if (div_ovf) pcpi_rd <= op_is_rem(op) ? '0 : pcpi_rs1;
        end
        MUL: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1))
            pcpi_rd <= (op == OP_MUL) ? mul_total[XLEN-1:0] : mul_total[W2-1:XLEN];
        end
        DIV: if (div_last) pcpi_rd <= div_result;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      mul_a     <= {{XLEN{op_rs1_signed(op) & pcpi_rs1[XLEN-1]}}, pcpi_rs1};
      mul_b     <= {{XLEN{op_rs2_signed(op) & pcpi_rs2[XLEN-1]}}, pcpi_rs2};
      acc_sum   <= '0;
      acc_carry <= '0;
      neg_q     <= op_div_signed(op) && (pcpi_rs1[XLEN-1] ^ pcpi_rs2[XLEN-1]);
      neg_r     <= op_div_signed(op) && pcpi_rs1[XLEN-1];
    end else if (state == MUL) begin
      mul_a     <= ms_a;
      mul_b     <= ms_b;
      acc_sum   <= ms_s;
      acc_carry <= ms_c;
    end
  end

  if (ENABLE_DIV != 0) begin : g_div
    picorv32_pcpi_div_core #(
      .XLEN(XLEN)
    ) u_div (
      .clk      (clk),
      .resetn   (resetn),
      .load     (div_load),
      .step     (div_step),
      .dividend (div_dividend),
      .divisor  (div_divisor),
      .quo_nxt  (div_quo_nxt),
      .rem_nxt  (div_rem_nxt),
      .last     (div_last)
    );
  end else begin : g_nodiv
    assign div_quo_nxt = '0;
    assign div_rem_nxt = '0;
    assign div_last    = 1'b0;
  end

endmodule

// File: tb/tb_picorv32_pcpi_muldiv.sv
// Bench for picorv32_pcpi_muldiv: directed vector table on a 32-bit instance,
// abort/reset sequences, and a random sweep on 16- and 64-bit instances.
module tb_picorv32_pcpi_muldiv;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  vld;
  logic [31:0] insn;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [3:0]  wr;
  logic [3:0]  wt;
  logic [3:0]  rdy;
  logic [3:0]  bsy;
  logic [31:0] rd0;
  logic [15:0] rd1;
  logic [63:0] rd2;
  logic [31:0] rd3;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] rd;
    int          lat;
  } vec_t;

  vec_t vt[16];

  always #5 clk = ~clk;

  picorv32_pcpi_muldiv #(.XLEN(32), .STEPS_AT_ONCE(1), .ENABLE_DIV(1)) dut0 (
    .clk(clk), .resetn(resetn), .pcpi_valid(vld[0]), .pcpi_insn(insn),
    .pcpi_rs1(rs1[31:0]), .pcpi_rs2(rs2[31:0]), .pcpi_wr(wr[0]), .pcpi_rd(rd0),
    .pcpi_wait(wt[0]), .pcpi_ready(rdy[0]), .busy(bsy[0]));

  picorv32_pcpi_muldiv #(.XLEN(16), .STEPS_AT_ONCE(4), .ENABLE_DIV(1)) dut1 (
    .clk(clk), .resetn(resetn), .pcpi_valid(vld[1]), .pcpi_insn(insn),
    .pcpi_rs1(rs1[15:0]), .pcpi_rs2(rs2[15:0]), .pcpi_wr(wr[1]), .pcpi_rd(rd1),
    .pcpi_wait(wt[1]), .pcpi_ready(rdy[1]), .busy(bsy[1]));

  picorv32_pcpi_muldiv #(.XLEN(64), .STEPS_AT_ONCE(4), .ENABLE_DIV(1)) dut2 (
    .clk(clk), .resetn(resetn), .pcpi_valid(vld[2]), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr[2]), .pcpi_rd(rd2),
    .pcpi_wait(wt[2]), .pcpi_ready(rdy[2]), .busy(bsy[2]));

  picorv32_pcpi_muldiv #(.XLEN(32), .STEPS_AT_ONCE(1), .ENABLE_DIV(0)) dut3 (
    .clk(clk), .resetn(resetn), .pcpi_valid(vld[3]), .pcpi_insn(insn),
    .pcpi_rs1(rs1[31:0]), .pcpi_rs2(rs2[31:0]), .pcpi_wr(wr[3]), .pcpi_rd(rd3),
    .pcpi_wait(wt[3]), .pcpi_ready(rdy[3]), .busy(bsy[3]));

  function automatic logic [31:0] mk_insn(input logic [2:0] f3);
    return {7'b0000001, 10'd0, f3, 5'd0, 7'b0110011};
  endfunction

  function automatic logic [63:0] get_rd(input int sel);
    case (sel)
      0:       return {32'd0, rd0};
      1:       return {48'd0, rd1};
      2:       return rd2;
      default: return {32'd0, rd3};
    endcase
  endfunction

  function automatic logic [63:0] xmask(input int xlen);
    return (xlen == 64) ? {64{1'b1}} : ((64'd1 << xlen) - 64'd1);
  endfunction

  // Reference results from wide signed/unsigned arithmetic on extended operands.
  function automatic logic [63:0] refm(input int xlen, input logic [2:0] f3,
                                       input logic [63:0] a, input logic [63:0] b);
    logic [63:0]         m;
    logic [127:0]        ua, ub, p;
    logic signed [127:0] sa, sb, q;
    m  = xmask(xlen);
    ua = {64'd0, a & m};
    ub = {64'd0, b & m};
    sa = $signed(ua << (128 - xlen)) >>> (128 - xlen);
    sb = $signed(ub << (128 - xlen)) >>> (128 - xlen);
    p  = '0;
    q  = '0;
    case (f3)
      3'd0: p = ua * ub;
      3'd1: begin q = sa * sb; p = q; p = p >> xlen; end
      3'd2: begin q = sa * $signed(ub); p = q; p = p >> xlen; end
      3'd3: p = (ua * ub) >> xlen;
      3'd4: if (ub == 0) p = '1; else begin q = sa / sb; p = q; end
      3'd5: if (ub == 0) p = '1; else p = ua / ub;
      3'd6: if (ub == 0) p = ua; else begin q = sa % sb; p = q; end
      default: if (ub == 0) p = ua; else p = ua % ub;
    endcase
    return p[63:0] & m;
  endfunction

  function automatic int exp_lat(input int xlen, input int steps, input logic [2:0] f3,
                                 input logic [63:0] a, input logic [63:0] b);
    if (f3 == 3'd0) return xlen / steps + 2;
    if (!f3[2]) return 2 * xlen / steps + 2;
    if ((b & xmask(xlen)) == 64'd0) return 2;
    if (!f3[0] && ((a & xmask(xlen)) == (64'd1 << (xlen - 1))) && ((b & xmask(xlen)) == xmask(xlen)))
      return 2;
    return xlen + 2;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request; latency counts cycles from the sampling cycle N.
  task automatic run_op(input int sel, input string name, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_rd, input int exp_lt);
    int          lat;
    logic [63:0] got;
    logic        got_wr;
    lat    = 0;
    got    = '0;
    got_wr = 1'b0;
    insn     = mk_insn(f3);
    rs1      = a;
    rs2      = b;
    vld[sel] = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 300; j++) begin
      @(posedge clk); #1;
      if (rdy[sel]) begin
        lat    = j + 1;
        got    = get_rd(sel);
        got_wr = wr[sel];
        break;
      end
    end
    vld[sel] = 1'b0;
    chk({name, "_rd"}, got, exp_rd);
    chk({name, "_lat"}, 64'(lat), 64'(exp_lt));
    chk({name, "_wr"}, {63'd0, got_wr}, 64'd1);
    @(posedge clk); #1;
    chk({name, "_oneshot"}, {63'd0, rdy[sel]}, 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic        seen;
    logic [63:0] a, b, m;
    int          xl, sel;

    vt[0]  = '{3'd0, 64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, 34};
    vt[1]  = '{3'd0, 64'h3,        64'h5,        64'hF,        34};
    vt[2]  = '{3'd1, 64'h80000000, 64'h80000000, 64'h40000000, 66};
    vt[3]  = '{3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 66};
    vt[4]  = '{3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 66};
    vt[5]  = '{3'd1, 64'hFFFFFFFF, 64'h2,        64'hFFFFFFFF, 66};
    vt[6]  = '{3'd4, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 34};
    vt[7]  = '{3'd6, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 34};
    vt[8]  = '{3'd4, 64'h7,        64'hFFFFFFFE, 64'hFFFFFFFD, 34};
    vt[9]  = '{3'd6, 64'h7,        64'hFFFFFFFE, 64'h1,        34};
    vt[10] = '{3'd5, 64'h64,       64'h0,        64'hFFFFFFFF, 2};
    vt[11] = '{3'd7, 64'h64,       64'h0,        64'h64,       2};
    vt[12] = '{3'd6, 64'h80000000, 64'hFFFFFFFF, 64'h0,        2};
    vt[13] = '{3'd4, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 2};
    vt[14] = '{3'd5, 64'hFFFFFFFF, 64'h10,       64'h0FFFFFFF, 34};
    vt[15] = '{3'd5, 64'h64,       64'h7,        64'hE,        34};

    resetn = 1'b0;
    vld    = '0;
    insn   = '0;
    rs1    = '0;
    rs2    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr",    {63'd0, wr[0]},  64'd0);
    chk("reset_wait",  {63'd0, wt[0]},  64'd0);
    chk("reset_ready", {63'd0, rdy[0]}, 64'd0);
    chk("reset_busy",  {63'd0, bsy[0]}, 64'd0);
    chk("reset_rd",    {32'd0, rd0},    64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++)
      run_op(0, $sformatf("vec%0d", i), vt[i].f3, vt[i].a, vt[i].b, vt[i].rd, vt[i].lat);

    // Reset in the middle of a divide discards it.
    insn   = mk_insn(3'd4);
    rs1    = 64'd1000;
    rs2    = 64'd7;
    vld[0] = 1'b1;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    chk("middiv_busy", {63'd0, bsy[0]}, 64'd1);
    resetn = 1'b0;
    #1;
    chk("rst_async_wr",    {63'd0, wr[0]},  64'd0);
    chk("rst_async_wait",  {63'd0, wt[0]},  64'd0);
    chk("rst_async_ready", {63'd0, rdy[0]}, 64'd0);
    chk("rst_async_busy",  {63'd0, bsy[0]}, 64'd0);
    chk("rst_async_rd",    {32'd0, rd0},    64'd0);
    vld[0] = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (rdy[0] | wr[0]) seen = 1'b1; end
    chk("rst_no_ready", {63'd0, seen}, 64'd0);
    run_op(0, "post_reset_mul", 3'd0, 64'd3, 64'd5, 64'd15, 34);

    // Abort a MULHU by dropping valid in cycle N+10.
    insn   = mk_insn(3'd3);
    rs1    = 64'hFFFFFFFF;
    rs2    = 64'h12345678;
    vld[0] = 1'b1;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    chk("abort_wait_active", {63'd0, wt[0]}, 64'd1);
    vld[0] = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy",  {63'd0, bsy[0]}, 64'd0);
    chk("abort_wait",  {63'd0, wt[0]},  64'd0);
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (rdy[0] | wr[0]) seen = 1'b1; end
    chk("abort_no_ready", {63'd0, seen}, 64'd0);

    // Non-matching instruction and divide on a divider-less instance are ignored.
    insn   = {7'b0000000, 10'd0, 3'b000, 5'd0, 7'b0110011};
    vld[0] = 1'b1;
    seen   = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (wt[0] | bsy[0]) seen = 1'b1; end
    vld[0] = 1'b0;
    chk("nomatch_ignored", {63'd0, seen}, 64'd0);
    insn   = mk_insn(3'd4);
    rs1    = 64'd100;
    rs2    = 64'd7;
    vld[3] = 1'b1;
    seen   = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (wt[3] | bsy[3]) seen = 1'b1; end
    vld[3] = 1'b0;
    @(posedge clk); #1;
    chk("nodiv_div_ignored", {63'd0, seen}, 64'd0);
    run_op(3, "nodiv_mul", 3'd0, 64'd3, 64'd5, 64'd15, 34);

    // Random sweep over the 16-bit and 64-bit instances.
    for (int s = 1; s <= 2; s++) begin
      sel = s;
      xl  = (s == 1) ? 16 : 64;
      m   = xmask(xl);
      for (int it = 0; it < 16; it++) begin
        a = {$urandom, $urandom} & m;
        b = {$urandom, $urandom} & m;
        if (it == 5 || it == 7) b = b & (m >> (xl / 2));
        if (it == 12) begin a = 64'd1 << (xl - 1); b = m; end
        if (it == 13 || it == 14) b = 64'd0;
        if (it == 6) a = a | (64'd1 << (xl - 1));
        run_op(sel, $sformatf("x%0d_it%0d", xl, it), it[2:0], a, b,
               refm(xl, it[2:0], a, b), exp_lat(xl, 4, it[2:0], a, b));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
